// File: rtl/lpc_io_host_pkg.sv
// Shared LPC encodings for the host initiator and peripheral decoder.
// Phase states and the LAD nibble codes both sides agree on.
package lpc_io_host_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR_H,
        ST_SYNC,
        ST_RDATA,
        ST_TAR_P,
        ST_ABORT,
        ST_ABORT_END,
        ST_DONE
    } lpc_state_e;

    localparam logic [3:0] LAD_START      = 4'h0;
    localparam logic [3:0] LAD_CYC_IOR    = 4'h0;
    localparam logic [3:0] LAD_CYC_IOW    = 4'h2;
    localparam logic [3:0] LAD_SYNC_READY = 4'h0;
    localparam logic [3:0] LAD_SYNC_SHORT = 4'h5;
    localparam logic [3:0] LAD_SYNC_LONG  = 4'h6;
    localparam logic [3:0] LAD_SYNC_ERR   = 4'hA;
    localparam logic [3:0] LAD_TAR        = 4'hF;

    function automatic logic [3:0] addr_nib(
        input logic [15:0] a,
        input logic [1:0]  i
    );
        logic [3:0] n;
        unique case (i)
            2'd0: n = a[15:12];
            2'd1: n = a[11:8];
            2'd2: n = a[7:4];
            default: n = a[3:0];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lpc_io_host_if.sv
// Request/done handshake between a local controller and the LPC host.
// master = controller side, slave = lpc_io_host side.
interface lpc_io_host_if;
    logic        Req;
    logic        ReqWr;
    logic [15:0] ReqAddr;
    logic [7:0]  ReqWData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [7:0]  RdData;

    modport master (
        output Req, ReqWr, ReqAddr, ReqWData,
        input  Busy, Done, Err, RdData
    );

    modport slave (
        input  Req, ReqWr, ReqAddr, ReqWData,
        output Busy, Done, Err, RdData
    );
endinterface

// File: rtl/lpc_lad_iobuf.sv
// 4-bit tristate pad buffer for LAD[3:0].
// din always reflects the pad, including the host's own drive.
module lpc_lad_iobuf (
    input  logic       oe,
    input  logic [3:0] dout,
    output logic [3:0] din,
    inout  wire  [3:0] pad
);
    assign pad = oe ? dout : 4'bz;
    assign din = pad;
endmodule

// File: rtl/lpc_io_host.sv
// LPC host initiator for single-byte I/O read/write cycles.
// Optional LPC_PORT80_MIRROR_EN adds the PostCode port-80 mirror.
module lpc_io_host
    import lpc_io_host_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 8,
    parameter int LONG_TIMEOUT = 1023
) (
    input  logic          lclk,
    input  logic          Reset,
    lpc_io_host_if.slave  host,
    output logic          lframe_n,
    inout  wire  [3:0]    lad
`ifdef LPC_PORT80_MIRROR_EN
    ,
    output logic [7:0]    PostCode
`endif
);

    localparam logic [9:0] SYNC_LIM = 10'(SYNC_TIMEOUT - 1);
    localparam logic [9:0] LONG_LIM = 10'(LONG_TIMEOUT - 1);

    lpc_state_e  st, st_n;
    logic [1:0]  pc, pc_n;
    logic [9:0]  wcnt, wcnt_eff;
    logic        wlong;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rbuf;
    logic        err_q;
    logic        accept;
    logic        sync_wait;
    logic        sync_long;
    logic        sync_to;
    logic        lad_oe, lad_oe_n;
    logic [3:0]  lad_do, lad_do_n;
    logic [3:0]  lad_di;
    logic        lframe_n_n;
    logic        fin_ok;

    lpc_lad_iobuf u_iobuf (
        .oe   (lad_oe),
        .dout (lad_do),
        .din  (lad_di),
        .pad  (lad)
    );

    always_comb begin
        st_n      = st;
        pc_n      = pc;
        accept    = 1'b0;
        sync_wait = 1'b0;
        sync_long = 1'b0;
        sync_to   = 1'b0;
        wcnt_eff  = wcnt;
        unique case (st)
            ST_IDLE, ST_DONE: begin
                if (host.Req) begin
                    st_n   = ST_START;
                    accept = 1'b1;
                end else begin
                    st_n = ST_IDLE;
                end
            end
            ST_START: st_n = ST_CYCTYPE;
            ST_CYCTYPE: begin
                st_n = ST_ADDR;
                pc_n = 2'd0;
            end
            ST_ADDR: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd3) begin
                    st_n = wr_q ? ST_WDATA : ST_TAR_H;
                    pc_n = 2'd0;
                end
            end
            ST_WDATA: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd1) begin
                    st_n = ST_TAR_H;
                    pc_n = 2'd0;
                end
            end
            ST_TAR_H: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd1) begin
                    st_n = ST_SYNC;
                    pc_n = 2'd0;
                end
            end
            ST_SYNC: begin
                if (lad_di == LAD_SYNC_READY ||
                    lad_di == LAD_SYNC_ERR) begin
                    st_n = wr_q ? ST_TAR_P : ST_RDATA;
                    pc_n = 2'd0;
                end else begin
                    // short->long restarts the count; long->short keeps it
                    sync_wait = 1'b1;
                    sync_long = (lad_di == LAD_SYNC_LONG);
                    if (sync_long && !wlong)
                        wcnt_eff = '0;
                    if (wcnt_eff >= (sync_long ? LONG_LIM : SYNC_LIM)) begin
                        sync_to = 1'b1;
                        st_n    = ST_ABORT;
                        pc_n    = 2'd0;
                    end
                end
            end
            ST_RDATA: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd1) begin
                    st_n = ST_TAR_P;
                    pc_n = 2'd0;
                end
            end
            ST_TAR_P: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd1) begin
                    st_n = ST_DONE;
                    pc_n = 2'd0;
                end
            end
            ST_ABORT: begin
                pc_n = pc + 2'd1;
                if (pc == 2'd3) begin
                    st_n = ST_ABORT_END;
                    pc_n = 2'd0;
                end
            end
            ST_ABORT_END: st_n = ST_DONE;
            default: st_n = ST_IDLE;
        endcase
    end

    always_comb begin
        lframe_n_n = !(st_n == ST_START || st_n == ST_ABORT);
        lad_oe_n   = 1'b0;
        lad_do_n   = 4'h0;
        unique case (st_n)
            ST_START: begin
                lad_oe_n = 1'b1;
                lad_do_n = LAD_START;
            end
            ST_CYCTYPE: begin
                lad_oe_n = 1'b1;
                lad_do_n = wr_q ? LAD_CYC_IOW : LAD_CYC_IOR;
            end
            ST_ADDR: begin
                lad_oe_n = 1'b1;
                lad_do_n = addr_nib(addr_q, pc_n);
            end
            ST_WDATA: begin
                lad_oe_n = 1'b1;
                lad_do_n = pc_n[0] ? wdata_q[7:4] : wdata_q[3:0];
            end
            ST_TAR_H: begin
                lad_oe_n = (pc_n == 2'd0);
                lad_do_n = LAD_TAR;
            end
            ST_ABORT: begin
                lad_oe_n = 1'b1;
                lad_do_n = LAD_TAR;
            end
            default: begin
                lad_oe_n = 1'b0;
                lad_do_n = 4'h0;
            end
        endcase
    end

    assign fin_ok = (st == ST_TAR_P) && (st_n == ST_DONE) && !err_q;

    always_ff @(posedge lclk) begin
        if (Reset) begin
            st          <= ST_IDLE;
            pc          <= 2'd0;
            wcnt        <= '0;
            wlong       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf        <= '0;
            err_q       <= 1'b0;
            lframe_n    <= 1'b1;
            lad_oe      <= 1'b0;
            lad_do      <= 4'h0;
            host.Busy   <= 1'b0;
            host.Done   <= 1'b0;
            host.Err    <= 1'b0;
            host.RdData <= '0;
        end else begin
            st       <= st_n;
            pc       <= pc_n;
            lframe_n <= lframe_n_n;
            lad_oe   <= lad_oe_n;
            lad_do   <= lad_do_n;
            host.Busy <= !(st_n == ST_IDLE || st_n == ST_DONE);
            host.Done <= (st_n == ST_DONE);
            host.Err  <= (st_n == ST_DONE) && err_q;
            if (accept) begin
                wr_q    <= host.ReqWr;
                addr_q  <= host.ReqAddr;
                wdata_q <= host.ReqWData;
                err_q   <= 1'b0;
            end
            if (st == ST_TAR_H) begin
                wcnt  <= '0;
                wlong <= 1'b0;
            end else if (sync_wait) begin
                wcnt  <= (&wcnt_eff) ? wcnt_eff : wcnt_eff + 10'd1;
                wlong <= sync_long;
            end
            if (st == ST_SYNC && lad_di == LAD_SYNC_ERR)
                err_q <= 1'b1;
            if (sync_to)
                err_q <= 1'b1;
            if (st == ST_RDATA) begin
                if (pc == 2'd0)
                    rbuf[3:0] <= lad_di;
                else
                    rbuf[7:4] <= lad_di;
            end
            if (fin_ok && !wr_q)
                host.RdData <= rbuf;
        end
    end

`ifdef LPC_PORT80_MIRROR_EN
    always_ff @(posedge lclk) begin
        if (Reset)
            PostCode <= '0;
        else if (fin_ok && wr_q && addr_q == 16'h0080)
            PostCode <= wdata_q;
    end
`endif

endmodule

// File: tb/tb_lpc_io_host.sv
// Self-checking bench for lpc_io_host: per-cycle trace model built
// from transaction fields and a scripted peripheral SYNC sequence.
module tb_lpc_io_host;

    localparam int SYNC_TO = 8;
    localparam int LONG_TO = 1023;

    logic       lclk = 1'b0;
    logic       Reset = 1'b1;
    logic       lframe_n;
    wire  [3:0] lad;
    logic       p_oe = 1'b0;
    logic [3:0] p_val = 4'h0;

    assign lad = p_oe ? p_val : 4'bz;

    lpc_io_host_if bus ();

`ifdef LPC_PORT80_MIRROR_EN
    logic [7:0] post;
`endif

    lpc_io_host #(
        .SYNC_TIMEOUT (SYNC_TO),
        .LONG_TIMEOUT (LONG_TO)
    ) dut (
        .lclk     (lclk),
        .Reset    (Reset),
        .host     (bus),
        .lframe_n (lframe_n),
        .lad      (lad)
`ifdef LPC_PORT80_MIRROR_EN
        ,
        .PostCode (post)
`endif
    );

    always #15 lclk = ~lclk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic       e_lf[$];
    logic       e_oe[$];
    logic [3:0] e_val[$];
    logic       d_oe[$];
    logic [3:0] d_val[$];
    logic [3:0] scr[$];
    logic [7:0] m_rd = 8'h00;
    logic [7:0] m_post = 8'h00;

    task automatic push(input logic lf, input logic oe,
                        input logic [3:0] v,
                        input logic doe, input logic [3:0] dv);
        e_lf.push_back(lf);
        e_oe.push_back(oe);
        e_val.push_back(v);
        d_oe.push_back(doe);
        d_val.push_back(dv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge lclk); #1;
            chk("idle_busy", bus.Busy, 0);
            chk("idle_done", bus.Done, 0);
            chk("idle_lframe", lframe_n, 1);
            chk("idle_oe", dut.lad_oe, 0);
            chk("idle_rd", bus.RdData, m_rd);
        end
    endtask

    task automatic run(input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] rdv);
        int cnt;
        bit lng, term, err, abrt;
        int n;
        logic [3:0] c;
        e_lf.delete(); e_oe.delete(); e_val.delete();
        d_oe.delete(); d_val.delete();
        push(0, 1, 4'h0, 0, 0);
        push(1, 1, wr ? 4'h2 : 4'h0, 0, 0);
        for (int i = 0; i < 4; i++)
            push(1, 1, a[15-4*i -: 4], 0, 0);
        if (wr) begin
            push(1, 1, d[3:0], 0, 0);
            push(1, 1, d[7:4], 0, 0);
        end
        push(1, 1, 4'hF, 0, 0);
        push(1, 0, 4'h0, 0, 0);
        cnt = 0; lng = 0; term = 0; err = 0; abrt = 0;
        for (int j = 0; j < scr.size() && !term && !abrt; j++) begin
            c = scr[j];
            push(1, 0, 4'h0, 1, c);
            if (c == 4'h0) term = 1;
            else if (c == 4'hA) begin term = 1; err = 1; end
            else if (c == 4'h6) begin
                if (!lng) cnt = 0;
                lng = 1; cnt++;
                if (cnt >= LONG_TO) abrt = 1;
            end else begin
                lng = 0; cnt++;
                if (cnt >= SYNC_TO) abrt = 1;
            end
        end
        if (abrt) begin
            repeat (4) push(0, 1, 4'hF, 0, 0);
            push(1, 0, 4'h0, 0, 0);
            err = 1;
        end else begin
            if (!wr) begin
                push(1, 0, 4'h0, 1, rdv[3:0]);
                push(1, 0, 4'h0, 1, rdv[7:4]);
            end
            push(1, 0, 4'h0, 0, 0);
            push(1, 0, 4'h0, 0, 0);
        end
        push(1, 0, 4'h0, 0, 0);
        n = e_lf.size();
        chk("acc_busy", bus.Busy, 0);
        bus.Req = 1; bus.ReqWr = wr;
        bus.ReqAddr = a; bus.ReqWData = d;
        @(posedge lclk); #1;
        bus.Req = 0;
        for (int k = 0; k < n; k++) begin
            bit last;
            last = (k == n - 1);
            if (last && !err) begin
                if (!wr) m_rd = rdv;
                if (wr && a == 16'h0080) m_post = d;
            end
            chk("lframe", lframe_n, e_lf[k]);
            chk("lad_oe", dut.lad_oe, e_oe[k]);
            if (e_oe[k]) chk("lad", lad, e_val[k]);
            chk("busy", bus.Busy, !last);
            chk("done", bus.Done, last);
            chk("err", bus.Err, last & err);
            chk("rddata", bus.RdData, m_rd);
`ifdef LPC_PORT80_MIRROR_EN
            chk("postcode", post, m_post);
`endif
            p_oe = d_oe[k];
            p_val = d_val[k];
            if (!last) begin
                bus.Req = 1'($urandom_range(0, 1));
                bus.ReqWr = 1'($urandom_range(0, 1));
                bus.ReqAddr = 16'($urandom);
                bus.ReqWData = 8'($urandom);
                @(posedge lclk); #1;
            end
        end
        p_oe = 0;
        bus.Req = 0;
    endtask

    task automatic fill(input int nw, input logic [3:0] code);
        repeat (nw) scr.push_back(code);
    endtask

    task automatic rand_scr();
        int kind;
        logic [3:0] w[4];
        w[0] = 4'h5; w[1] = 4'h6; w[2] = 4'hF; w[3] = 4'h3;
        scr.delete();
        kind = $urandom_range(0, 5);
        if (kind == 0) begin
            fill(10, 4'hF);
        end else begin
            repeat ($urandom_range(0, 4))
                scr.push_back(w[$urandom_range(0, 3)]);
            scr.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
        end
    endtask

    initial begin
        logic [15:0] a;
        bus.Req = 0; bus.ReqWr = 0;
        bus.ReqAddr = 0; bus.ReqWData = 0;
        repeat (3) @(posedge lclk);
        #1;
        chk("rst_lframe", lframe_n, 1);
        chk("rst_oe", dut.lad_oe, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_err", bus.Err, 0);
        chk("rst_rd", bus.RdData, 8'h00);
`ifdef LPC_PORT80_MIRROR_EN
        chk("rst_post", post, 8'h00);
`endif
        Reset = 0;
        idle(2);

        scr = '{4'h0};
        run(1, 16'h0801, 8'h5A, 8'h00);
        idle(1);
        scr = '{4'h0};
        run(0, 16'h08AA, 8'h00, 8'hC3);
        idle(1);
        scr = '{4'h5, 4'h5, 4'h5, 4'h0};
        run(0, 16'h0812, 8'h00, 8'h96);
        idle(1);
        scr.delete(); fill(12, 4'hF);
        run(0, 16'h0813, 8'h00, 8'h11);
        idle(1);
        scr = '{4'hA};
        run(1, 16'h0820, 8'h42, 8'h00);
        scr = '{4'h5, 4'hA};
        run(0, 16'h0821, 8'h00, 8'h77);
        idle(1);
        scr.delete(); fill(20, 4'h6); scr.push_back(4'h0);
        run(0, 16'h0830, 8'h00, 8'hE4);
        scr.delete(); fill(20, 4'h6); scr.push_back(4'h5);
        run(0, 16'h0831, 8'h00, 8'h01);
        scr.delete(); fill(7, 4'h5); fill(5, 4'h6);
        scr.push_back(4'h0);
        run(1, 16'h0832, 8'h9D, 8'h00);
        idle(1);
        scr.delete(); fill(1030, 4'h6);
        run(0, 16'h0833, 8'h00, 8'h55);
        idle(1);

        scr = '{4'h0};
        run(1, 16'h0080, 8'h3C, 8'h00);
        scr = '{4'h0};
        run(1, 16'h0081, 8'h77, 8'h00);
        scr = '{4'hA};
        run(1, 16'h0080, 8'hE1, 8'h00);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            rand_scr();
            a = ($urandom_range(0, 3) == 0) ? 16'h0080 : 16'($urandom);
            run(1'($urandom_range(0, 1)), a,
                8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        bus.Req = 1; bus.ReqWr = 1;
        bus.ReqAddr = 16'h0801; bus.ReqWData = 8'hAB;
        @(posedge lclk); #1;
        bus.Req = 0;
        repeat (3) @(posedge lclk);
        #1;
        chk("pre_rst_busy", bus.Busy, 1);
        Reset = 1;
        @(posedge lclk); #1;
        Reset = 0;
        m_rd = 8'h00;
        m_post = 8'h00;
        chk("mid_rst_lframe", lframe_n, 1);
        chk("mid_rst_oe", dut.lad_oe, 0);
        chk("mid_rst_busy", bus.Busy, 0);
        chk("mid_rst_done", bus.Done, 0);
        chk("mid_rst_rd", bus.RdData, 8'h00);
`ifdef LPC_PORT80_MIRROR_EN
        chk("mid_rst_post", post, 8'h00);
`endif
        idle(4);
        scr = '{4'h0};
        run(0, 16'h0840, 8'h00, 8'h5C);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
